// File: rtl/partition_eval_pkg.sv
// Shared types and helpers for the partition evaluation blocks.
//   state_t   : sweep controller states
//   popcount  : number of set bits in a (zero-extended) 32-bit word
//   abs_diff  : |a - b| of two unsigned words; callers cast the result back to
//               their own width
package partition_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/err_accum.sv
// Error accumulators for one exact/approximate partition pair.
//   clk, rst_n        : clock, async active-low reset
//   i_clear           : zero all accumulators (start of a sweep)
//   i_sample          : fold the current exact/approx pair into the totals
//   i_exact, i_approx : partition outputs being compared
//   o_mismatch_cnt    : vectors where the outputs differ
//   o_hamming_sum     : summed popcount of exact ^ approx
//   o_max_abs_err     : largest |exact - approx| seen
module err_accum
    import partition_eval_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int NUM_OUT = 3
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_clear,
    input  logic                                  i_sample,
    input  logic [NUM_OUT-1:0]                    i_exact,
    input  logic [NUM_OUT-1:0]                    i_approx,
    output logic [NUM_IN:0]                       o_mismatch_cnt,
    output logic [NUM_IN+$clog2(NUM_OUT+1)-1:0]   o_hamming_sum,
    output logic [NUM_OUT-1:0]                    o_max_abs_err
);

    localparam int CW = NUM_IN + 1;
    localparam int HW = NUM_IN + $clog2(NUM_OUT + 1);

    logic [CW-1:0]      r_mismatch_cnt;
    logic [HW-1:0]      r_hamming_sum;
    logic [NUM_OUT-1:0] r_max_abs_err;

    logic [NUM_OUT-1:0] w_diff;
    logic [HW-1:0]      w_pop;
    logic [NUM_OUT-1:0] w_abs;

    assign w_diff = i_exact ^ i_approx;
    assign w_pop  = HW'(popcount(32'(w_diff)));
    assign w_abs  = NUM_OUT'(abs_diff(32'(i_exact), 32'(i_approx)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mismatch_cnt <= '0;
            r_hamming_sum  <= '0;
            r_max_abs_err  <= '0;
        end else if (i_clear) begin
            r_mismatch_cnt <= '0;
            r_hamming_sum  <= '0;
            r_max_abs_err  <= '0;
        end else if (i_sample) begin
            if (w_diff != '0) begin
                r_mismatch_cnt <= r_mismatch_cnt + CW'(1);
            end
            r_hamming_sum <= r_hamming_sum + w_pop;
            if (w_abs > r_max_abs_err) begin
                r_max_abs_err <= w_abs;
            end
        end
    end

    assign o_mismatch_cnt = r_mismatch_cnt;
    assign o_hamming_sum  = r_hamming_sum;
    assign o_max_abs_err  = r_max_abs_err;

endmodule

// File: rtl/partition_err_monitor.sv
// Sweeps all 2^NUM_IN input vectors of a partition, waits SETTLE cycles per
// vector, then compares the exact and approximate outputs and accumulates
// error metrics. Results are held until the next accepted start.
//   clk, rst_n            : clock, async active-low reset
//   start                 : begin a sweep (only honoured in IDLE)
//   pi_o                  : vector driven to both partition instances
//   exact_po, approx_po   : partition outputs
//   busy                  : high in SETTLE and SAMPLE
//   done                  : one-cycle pulse after the last sample
//   mismatch_cnt, hamming_sum, max_abs_err : accumulated results
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start, results from the last sweep held
// ST_SETTLE | pi_o stable, wait counter running down to 0
// ST_SAMPLE | compare outputs, advance to next vector or finish
// ST_DONE   | done pulse, back to IDLE
module partition_err_monitor
    import partition_eval_pkg::*;
#(
    parameter int NUM_IN  = 5,
    parameter int NUM_OUT = 3,
    parameter int SETTLE  = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    output logic [NUM_IN-1:0]                     pi_o,
    input  logic [NUM_OUT-1:0]                    exact_po,
    input  logic [NUM_OUT-1:0]                    approx_po,
    output logic                                  busy,
    output logic                                  done,
    output logic [NUM_IN:0]                       mismatch_cnt,
    output logic [NUM_IN+$clog2(NUM_OUT+1)-1:0]   hamming_sum,
    output logic [NUM_OUT-1:0]                    max_abs_err
);

    // Wait counter only has to hold SETTLE-1; keep at least one bit.
    localparam int                WW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WW-1:0]     WAIT_LOAD = WW'(SETTLE - 1);
    localparam logic [NUM_IN-1:0] PI_LAST   = '1;

    state_t             r_state;
    state_t             w_next;
    logic [NUM_IN-1:0]  r_pi;
    logic [WW-1:0]      r_wait;
    logic               w_clear;
    logic               w_sample;
    logic               w_wait_zero;
    logic               w_last;

    assign w_wait_zero = (r_wait == '0);
    assign w_last      = (r_pi == PI_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start)       w_next = ST_SETTLE;
            ST_SETTLE: if (w_wait_zero) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = w_last ? ST_DONE : ST_SETTLE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        w_clear  = 1'b0;
        w_sample = 1'b0;
        case (r_state)
            ST_IDLE:   w_clear  = start;
            ST_SETTLE: busy     = 1'b1;
            ST_SAMPLE: begin
                busy     = 1'b1;
                w_sample = 1'b1;
            end
            ST_DONE:   done     = 1'b1;
            default:   ;
        endcase
    end

    // Vector and wait counters. pi_o is left at all ones after the final
    // sample so the last vector stays on the partition inputs while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pi   <= '0;
            r_wait <= '0;
        end else if (w_clear) begin
            r_pi   <= '0;
            r_wait <= WAIT_LOAD;
        end else if (r_state == ST_SETTLE) begin
            if (!w_wait_zero) begin
                r_wait <= r_wait - WW'(1);
            end
        end else if (r_state == ST_SAMPLE) begin
            if (!w_last) begin
                r_pi   <= r_pi + NUM_IN'(1);
                r_wait <= WAIT_LOAD;
            end
        end
    end

    assign pi_o = r_pi;

    err_accum #(
        .NUM_IN  (NUM_IN),
        .NUM_OUT (NUM_OUT)
    ) u_err_accum (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clear        (w_clear),
        .i_sample       (w_sample),
        .i_exact        (exact_po),
        .i_approx       (approx_po),
        .o_mismatch_cnt (mismatch_cnt),
        .o_hamming_sum  (hamming_sum),
        .o_max_abs_err  (max_abs_err)
    );

endmodule

// File: tb/tb_partition_err_monitor.sv
module tb_partition_err_monitor;

    localparam int N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n  = 1'b0;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;

    logic [4:0] pi1, pi3;
    logic [2:0] ex1, ap1, ex3, ap3, r_dly;
    logic       busy1, done1, busy3, done3;
    logic [5:0] mc1, mc3;
    logic [6:0] hs1, hs3;
    logic [2:0] mx1, mx3;

    logic [2:0] tbl_e [N];
    logic [2:0] tbl_a [N];

    // Default instance: partitions are lookup tables indexed by the vector.
    assign ex1 = tbl_e[pi1];
    assign ap1 = tbl_a[pi1];

    // SETTLE=3 instance: approx is a one-cycle-late copy of exact.
    assign ex3 = pi3[2:0];
    always @(posedge clk) r_dly <= ex3;
    assign ap3 = r_dly;

    partition_err_monitor #(.NUM_IN(5), .NUM_OUT(3), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .pi_o(pi1),
        .exact_po(ex1), .approx_po(ap1), .busy(busy1), .done(done1),
        .mismatch_cnt(mc1), .hamming_sum(hs1), .max_abs_err(mx1)
    );

    partition_err_monitor #(.NUM_IN(5), .NUM_OUT(3), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .pi_o(pi3),
        .exact_po(ex3), .approx_po(ap3), .busy(busy3), .done(done3),
        .mismatch_cnt(mc3), .hamming_sum(hs3), .max_abs_err(mx3)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_c[d] = index of the current cycle counted from the accepted start
    // (cycle 1 is the first after the accepting edge); 0 = no sweep since reset.
    int m_c  [2];
    int sn_e [2][N];
    int sn_a [2][N];

    function automatic int period(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic bit model_idle(input int d, input int c);
        return (c == 0) || (c >= N * period(d) + 2);
    endfunction

    function automatic void model_acc(input int d, input int ns,
                                      output int cnt, output int ham, output int mx);
        int e, a, ad;
        cnt = 0; ham = 0; mx = 0;
        for (int v = 0; v < ns; v++) begin
            e = sn_e[d][v];
            a = sn_a[d][v];
            if (e != a) cnt++;
            ham += $countones(e ^ a);
            ad = (e > a) ? e - a : a - e;
            if (ad > mx) mx = ad;
        end
    endfunction

    initial begin
        m_c[0] = 0;
        m_c[1] = 0;
        for (int v = 0; v < N; v++) begin
            tbl_e[v] = 3'd0;
            tbl_a[v] = 3'd0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_c[0] <= 0;
            m_c[1] <= 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (((d == 0) ? start1 : start3) && model_idle(d, m_c[d])) begin
                    m_c[d] <= 1;
                    for (int v = 0; v < N; v++) begin
                        sn_e[d][v] <= (d == 0) ? int'(tbl_e[v]) : v % 8;
                        sn_a[d][v] <= (d == 0) ? int'(tbl_a[v]) : v % 8;
                    end
                end else if (m_c[d] > 0 && m_c[d] < N * period(d) + 2) begin
                    m_c[d] <= m_c[d] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int c, p, eb, ed, ep, ns, ecnt, eham, emx;
        for (int d = 0; d < 2; d++) begin
            c = m_c[d];
            p = period(d);
            if (c == 0) begin
                eb = 0; ed = 0; ep = 0; ns = 0;
            end else if (c <= N * p) begin
                eb = 1; ed = 0; ep = (c - 1) / p; ns = (c - 1) / p;
            end else if (c == N * p + 1) begin
                eb = 0; ed = 1; ep = N - 1; ns = N;
            end else begin
                eb = 0; ed = 0; ep = N - 1; ns = N;
            end
            model_acc(d, ns, ecnt, eham, emx);
            if (d == 0) begin
                chk("busy", int'(busy1), eb);
                chk("done", int'(done1), ed);
                chk("pi_o", int'(pi1), ep);
                chk("mismatch_cnt", int'(mc1), ecnt);
                chk("hamming_sum", int'(hs1), eham);
                chk("max_abs_err", int'(mx1), emx);
            end else begin
                chk("busy_s3", int'(busy3), eb);
                chk("done_s3", int'(done3), ed);
                chk("pi_o_s3", int'(pi3), ep);
                chk("mismatch_cnt_s3", int'(mc3), ecnt);
                chk("hamming_sum_s3", int'(hs3), eham);
                chk("max_abs_err_s3", int'(mx3), emx);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Returns the cycle index in which done was seen, 0 if aborted by reset,
    // -1 if the cycle budget ran out.
    task automatic run_sweep(input int d, input int inject_k, input int reset_k, output int got);
        int k;
        got = -1;
        @(posedge clk); #1;
        if (d == 0) start1 = 1'b1; else start3 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start3 = 1'b0;
        k = 1;
        while (k < 400) begin
            @(negedge clk);
            if (((d == 0) ? done1 : done3) === 1'b1) begin
                got = k;
                break;
            end
            if (k == inject_k) begin
                if (d == 0) start1 = 1'b1; else start3 = 1'b1;
            end
            if (k == reset_k) begin
                #2 rst_n = 1'b0;
                repeat (3) @(negedge clk);
                #2 rst_n = 1'b1;
                got = 0;
                break;
            end
            @(posedge clk); #1;
            start1 = 1'b0;
            start3 = 1'b0;
            k++;
        end
    endtask

    task automatic chk_res1(input string tag, input int cnt, input int ham, input int mx);
        chk({tag, "_mismatch"}, int'(mc1), cnt);
        chk({tag, "_hamming"},  int'(hs1), ham);
        chk({tag, "_maxerr"},   int'(mx1), mx);
    endtask

    task automatic randomize_tables();
        for (int v = 0; v < N; v++) begin
            tbl_e[v] = 3'($urandom_range(0, 7));
            tbl_a[v] = ($urandom_range(0, 3) == 0) ? tbl_e[v] : 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        int got, c, h, m;
        logic [4:0] vv;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pi_o", int'(pi1), 0);
        chk("reset_busy", int'(busy1), 0);
        chk("reset_done", int'(done1), 0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // exact == approx
        for (int v = 0; v < N; v++) begin
            vv = 5'(v);
            tbl_e[v] = vv[2:0];
            tbl_a[v] = vv[2:0];
        end
        run_sweep(0, -1, -1, got);
        chk("tied_done_cycle", got, 65);
        chk_res1("tied", 0, 0, 0);

        // approx stuck at zero
        for (int v = 0; v < N; v++) tbl_a[v] = 3'd0;
        run_sweep(0, -1, -1, got);
        chk("zero_done_cycle", got, 65);
        chk_res1("zero", 28, 48, 7);
        model_acc(0, N, c, h, m);
        chk("model_zero_mismatch", c, 28);
        chk("model_zero_hamming", h, 48);
        chk("model_zero_maxerr", m, 7);

        // approx flips the LSB
        for (int v = 0; v < N; v++) tbl_a[v] = tbl_e[v] ^ 3'b001;
        run_sweep(0, -1, -1, got);
        chk("lsb_done_cycle", got, 65);
        chk_res1("lsb", 32, 32, 1);

        // start re-pulsed mid-sweep must be ignored
        for (int v = 0; v < N; v++) tbl_a[v] = 3'd0;
        run_sweep(0, 20, -1, got);
        chk("restart_done_cycle", got, 65);
        chk_res1("restart", 28, 48, 7);
        repeat (4) @(posedge clk);

        // SETTLE=3 with a delayed approx: settle window must hide the lag
        run_sweep(1, -1, -1, got);
        chk("s3_done_cycle", got, 129);
        chk("s3_mismatch", int'(mc3), 0);
        chk("s3_hamming", int'(hs3), 0);
        chk("s3_maxerr", int'(mx3), 0);

        // reset mid-sweep, then a fresh random sweep
        randomize_tables();
        run_sweep(0, -1, 30, got);
        chk("abort_by_reset", got, 0);
        repeat (5) @(posedge clk);
        for (int r = 0; r < 3; r++) begin
            randomize_tables();
            run_sweep(0, -1, -1, got);
            chk("rand_done_cycle", got, 65);
            model_acc(0, N, c, h, m);
            chk_res1("rand", c, h, m);
            repeat ($urandom_range(1, 4)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/partition_err_monitor.md
# partition_err_monitor

- Response-side companion to the partition stimulus benches.
- Sweeps every input pattern of a NUM_IN-input / NUM_OUT-output partition and drives it to an exact and an approximate instance of that partition.
- After a programmable settle time, samples both instances' outputs and accumulates error metrics: mismatch count, summed Hamming distance and maximum absolute error.
- Sits beside the partition instances in the evaluation harness, replacing per-vector console dumps with a start/done handshake and held results.

## Interface
Parameters:
- NUM_IN, 5, partition input width; the sweep covers 2^NUM_IN vectors.
- NUM_OUT, 3, partition output width.
- SETTLE, 1, cycles between driving a vector and sampling outputs; must be at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- pi_o  out  NUM_IN  vector driven to both partition instances.
- exact_po  in  NUM_OUT  exact partition output.
- approx_po  in  NUM_OUT  approximate partition output.
- busy  out  1  high while sweeping (SETTLE or SAMPLE states).
- done  out  1  one-cycle pulse when the sweep completes.
- mismatch_cnt  out  NUM_IN+1  number of vectors with exact_po != approx_po.
- hamming_sum  out  NUM_IN+$clog2(NUM_OUT+1)  sum of popcount(exact_po ^ approx_po).
- max_abs_err  out  NUM_OUT  maximum of |exact_po - approx_po|, both operands unsigned.

## Operation
States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 clears all three accumulators, sets pi_o=0, loads the wait counter with SETTLE-1, and moves to SETTLE.
  - Otherwise holds. Results stay valid from the previous sweep.
- SETTLE:
  - pi_o is held stable.
  - Stays for exactly SETTLE cycles, decrementing the wait counter.
  - Moves to SAMPLE when the counter reads 0.
- SAMPLE (one cycle): compares the current exact_po/approx_po and updates the accumulators.
  - mismatch_cnt increments by 1 if the outputs differ.
  - hamming_sum adds the popcount of the XOR.
  - max_abs_err takes the larger of its current value and the absolute difference.
  - If pi_o is all ones, moves to DONE.
  - Otherwise increments pi_o, reloads the wait counter and moves to SETTLE.
- DONE: done=1 for one cycle, then IDLE. pi_o holds its final value (all ones) until the next start.
- start asserted in SETTLE, SAMPLE or DONE is ignored; no queuing.
- Accumulator widths are sized so no overflow is possible; no saturation logic is needed.
- Reset mid-sweep returns to IDLE immediately and clears all state. No done pulse is emitted for the aborted sweep.

## Timing
- Reset values: pi_o=0, busy=0, done=0, mismatch_cnt=0, hamming_sum=0, max_abs_err=0, state=IDLE.
- Start is accepted at edge 0 (state IDLE, start=1).
  - Vector k is driven from cycle 1+k*(SETTLE+1).
  - Vector k is sampled in cycle 1+k*(SETTLE+1)+SETTLE.
- The last sample occurs in cycle 2^NUM_IN*(SETTLE+1).
  - done is high in cycle 2^NUM_IN*(SETTLE+1)+1.
  - Defaults (NUM_IN=5, SETTLE=1): last sample in cycle 64, done in cycle 65.
- busy is high in cycles 1 through 2^NUM_IN*(SETTLE+1) and low in the DONE cycle.
- Accumulator outputs are registered.
  - They update on the edge ending each SAMPLE cycle.
  - They are final and stable in the cycle where done is high, and remain so until the next accepted start.
- The partition instances are combinational. Each is sampled SETTLE cycles after pi_o changes, so partition delay must be below SETTLE clock periods.

## Structure
- Shared package partition_eval_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - a popcount function;
  - an abs_diff function, parameterised by width through the caller's cast.
- One sub-module, err_accum, is natural. It takes exact_po, approx_po, a clear strobe and a sample-enable, and owns the three accumulators. The top level owns the FSM, the vector counter (pi_o) and the wait counter.

## Test plan
- approx_po tied to exact_po (both = pi_o[2:0]), defaults -> done in cycle 65; mismatch_cnt=0, hamming_sum=0, max_abs_err=0.
- exact_po=pi_o[2:0], approx_po=0 -> mismatch_cnt=28, hamming_sum=48, max_abs_err=7.
- exact_po=pi_o[2:0], approx_po=pi_o[2:0]^3'b001 -> mismatch_cnt=32, hamming_sum=32, max_abs_err=1.
- SETTLE=3, approx_po driven from a one-cycle-delayed copy of exact_po -> no mismatches (checks the settle window); done in cycle 129.
- start pulsed again at cycle 20 of a sweep -> ignored; a single done at cycle 65; results identical to an undisturbed run.
- rst_n asserted at cycle 30 then released, then start -> all outputs 0 during reset; no done for the aborted sweep; the fresh sweep produces correct totals.
